// File: rtl/wfg_record_pat_pkg.sv
// Shared types and constants for the pattern recorder: FSM state encoding
// and the geometry of the small output FIFO.
package wfg_record_pat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_ARMED     = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/wfg_record_pat_fifo.sv
// Tiny FIFO holding {tlast, tdata} words between the sampler and the stream.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module wfg_record_pat_fifo
  import wfg_record_pat_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_push_ok,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] r_wr_ptr;
  logic [FIFO_PTR_W-1:0] r_rd_ptr;
  logic [FIFO_CNT_W-1:0] r_count;

  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign o_valid   = (r_count != '0);
  assign w_full    = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
  assign w_pop     = i_pop && o_valid;
  assign w_push_ok = i_push && (!w_full || w_pop);
  assign o_push_ok = w_push_ok;
  // Output reads as zero while empty so reset leaves tdata/tlast at 0.
  assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;

  function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] p);
    return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + FIFO_CNT_W'(w_push_ok) - FIFO_CNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/wfg_record_pat.sv
// Pattern recorder: samples the input pins once per pattern cycle at a
// configurable subcycle and streams the words out as AXI-stream packets.
module wfg_record_pat
  import wfg_record_pat_pkg::*;
#(
  parameter int CHANNELS   = 8,
  parameter int AXIS_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pat_sync_i,
  input  logic [7:0]            pat_subcycle_cnt_i,
  input  logic                  ctrl_en_q_i,
  input  logic [7:0]            cfg_sample_q_i,
  input  logic [7:0]            cfg_len_q_i,
  input  logic [CHANNELS-1:0]   pat_din_i,
  input  logic                  ovf_clr_i,
  output logic                  wfg_axis_tvalid_o,
  input  logic                  wfg_axis_tready_i,
  output logic                  wfg_axis_tlast_o,
  output logic [AXIS_WIDTH-1:0] wfg_axis_tdata_o,
  output logic                  ovf_o
);

  state_t r_state;
  state_t w_state_next;

  logic            w_match;
  logic            w_sample;
  logic            w_tlast;
  logic            w_push_ok;
  logic            w_pop;
  logic [7:0]      r_word_cnt;
  logic            r_ovf;
  logic [AXIS_WIDTH:0] w_fifo_din;
  logic [AXIS_WIDTH:0] w_fifo_dout;

  assign w_match = (pat_subcycle_cnt_i == cfg_sample_q_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!ctrl_en_q_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      w_state_next = ST_WAIT_SYNC;
        ST_WAIT_SYNC: if (pat_sync_i && !w_match) w_state_next = ST_ARMED;
        ST_ARMED:     if (w_match) w_state_next = ST_WAIT_SYNC;
        default:      w_state_next = ST_IDLE;
      endcase
    end
  end

  // A sync that coincides with the sample subcycle samples immediately.
  always_comb begin
    w_sample = 1'b0;
    if (ctrl_en_q_i) begin
      case (r_state)
        ST_WAIT_SYNC: w_sample = pat_sync_i && w_match;
        ST_ARMED:     w_sample = w_match;
        default:      w_sample = 1'b0;
      endcase
    end
  end

  assign w_tlast    = (r_word_cnt == cfg_len_q_i);
  assign w_fifo_din = {w_tlast, AXIS_WIDTH'(pat_din_i)};
  assign w_pop      = wfg_axis_tvalid_o && wfg_axis_tready_i;

  wfg_record_pat_fifo #(
    .WIDTH (AXIS_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_sample),
    .i_data    (w_fifo_din),
    .o_push_ok (w_push_ok),
    .i_pop     (w_pop),
    .o_valid   (wfg_axis_tvalid_o),
    .o_data    (w_fifo_dout)
  );

  assign wfg_axis_tlast_o = w_fifo_dout[AXIS_WIDTH];
  assign wfg_axis_tdata_o = w_fifo_dout[AXIS_WIDTH-1:0];

  // Dropped samples do not advance the packet position.
  always_ff @(posedge clk) begin
    if (rst || r_state == ST_IDLE) begin
      r_word_cnt <= '0;
    end else if (w_push_ok) begin
      r_word_cnt <= w_tlast ? 8'd0 : r_word_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_sample && !w_push_ok) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr_i) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf_o = r_ovf;

endmodule

// File: tb/tb_wfg_record_pat.sv
// Directed bench for wfg_record_pat: 4-subcycle pattern cycles driven by hand,
// outputs checked 1 ns after each rising edge against hand-computed values.
module tb_wfg_record_pat;

  logic        clk = 1'b0;
  logic        rst;
  logic        pat_sync_i;
  logic [7:0]  pat_subcycle_cnt_i;
  logic        ctrl_en_q_i;
  logic [7:0]  cfg_sample_q_i;
  logic [7:0]  cfg_len_q_i;
  logic [7:0]  pat_din_i;
  logic        ovf_clr_i;
  logic        wfg_axis_tvalid_o;
  logic        wfg_axis_tready_i;
  logic        wfg_axis_tlast_o;
  logic [31:0] wfg_axis_tdata_o;
  logic        ovf_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wfg_record_pat #(
    .CHANNELS   (8),
    .AXIS_WIDTH (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pat_sync_i         (pat_sync_i),
    .pat_subcycle_cnt_i (pat_subcycle_cnt_i),
    .ctrl_en_q_i        (ctrl_en_q_i),
    .cfg_sample_q_i     (cfg_sample_q_i),
    .cfg_len_q_i        (cfg_len_q_i),
    .pat_din_i          (pat_din_i),
    .ovf_clr_i          (ovf_clr_i),
    .wfg_axis_tvalid_o  (wfg_axis_tvalid_o),
    .wfg_axis_tready_i  (wfg_axis_tready_i),
    .wfg_axis_tlast_o   (wfg_axis_tlast_o),
    .wfg_axis_tdata_o   (wfg_axis_tdata_o),
    .ovf_o              (ovf_o)
  );

  task automatic tick(input logic sync, input logic [7:0] sub);
    pat_sync_i         = sync;
    pat_subcycle_cnt_i = sub;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("t=%0t %s observed=%h expected=%h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pat_sync_i = 1'b0; pat_subcycle_cnt_i = 8'd0; ctrl_en_q_i = 1'b0;
    cfg_sample_q_i = 8'd0; cfg_len_q_i = 8'd0; pat_din_i = 8'd0; ovf_clr_i = 1'b0;
    wfg_axis_tready_i = 1'b0;
    tick(0, 0);
    tick(0, 0);
    rst = 1'b0;
    tick(0, 0);
    check("reset_tvalid", 32'(wfg_axis_tvalid_o), 32'd0);
    check("reset_tlast",  32'(wfg_axis_tlast_o),  32'd0);
    check("reset_tdata",  wfg_axis_tdata_o,       32'd0);
    check("reset_ovf",    32'(ovf_o),             32'd0);

    // Two-word packet, sample at subcycle 3
    cfg_sample_q_i = 8'd3; cfg_len_q_i = 8'd1; wfg_axis_tready_i = 1'b1; ctrl_en_q_i = 1'b1;
    tick(0, 0);
    pat_din_i = 8'hA5;
    tick(1, 0); tick(0, 1); tick(0, 2);
    check("no_early_sample", 32'(wfg_axis_tvalid_o), 32'd0);
    tick(0, 3);
    check("w0_tvalid", 32'(wfg_axis_tvalid_o), 32'd1);
    check("w0_tdata",  wfg_axis_tdata_o,       32'h0000_00A5);
    check("w0_tlast",  32'(wfg_axis_tlast_o),  32'd0);
    pat_din_i = 8'h5A;
    tick(1, 0);
    check("w0_popped", 32'(wfg_axis_tvalid_o), 32'd0);
    tick(0, 1); tick(0, 2); tick(0, 3);
    check("w1_tvalid", 32'(wfg_axis_tvalid_o), 32'd1);
    check("w1_tdata",  wfg_axis_tdata_o,       32'h0000_005A);
    check("w1_tlast",  32'(wfg_axis_tlast_o),  32'd1);

    // Sample subcycle 0 coinciding with sync
    cfg_sample_q_i = 8'd0; pat_din_i = 8'h3C;
    tick(1, 0);
    check("sync_sample_tvalid", 32'(wfg_axis_tvalid_o), 32'd1);
    check("sync_sample_tdata",  wfg_axis_tdata_o,       32'h0000_003C);
    check("sync_sample_tlast",  32'(wfg_axis_tlast_o),  32'd0);
    tick(0, 1);
    check("sync_sample_popped", 32'(wfg_axis_tvalid_o), 32'd0);
    pat_din_i = 8'hC3;
    tick(1, 0);
    check("sync_sample2_tdata", wfg_axis_tdata_o,      32'h0000_00C3);
    check("sync_sample2_tlast", 32'(wfg_axis_tlast_o), 32'd1);
    tick(0, 1);

    // Backpressure for three pattern cycles
    wfg_axis_tready_i = 1'b0; cfg_sample_q_i = 8'd2; cfg_len_q_i = 8'd7;
    pat_din_i = 8'h11;
    tick(1, 0); tick(0, 1); tick(0, 2); tick(0, 3);
    pat_din_i = 8'h22;
    tick(1, 0); tick(0, 1); tick(0, 2);
    check("held_tvalid", 32'(wfg_axis_tvalid_o), 32'd1);
    check("held_tdata",  wfg_axis_tdata_o,       32'h0000_0011);
    check("no_ovf_yet",  32'(ovf_o),             32'd0);
    tick(0, 3);
    pat_din_i = 8'h33;
    tick(1, 0); tick(0, 1); tick(0, 2);
    check("ovf_set",       32'(ovf_o),            32'd1);
    check("ovf_held_data", wfg_axis_tdata_o,      32'h0000_0011);
    check("ovf_held_last", 32'(wfg_axis_tlast_o), 32'd0);
    ovf_clr_i = 1'b1;
    tick(0, 3);
    ovf_clr_i = 1'b0;
    check("ovf_cleared", 32'(ovf_o), 32'd0);

    // Full FIFO with a pop in the sample cycle
    pat_din_i = 8'h44;
    tick(1, 0); tick(0, 1);
    wfg_axis_tready_i = 1'b1;
    tick(0, 2);
    check("full_pop_no_ovf", 32'(ovf_o),       32'd0);
    check("full_pop_head",   wfg_axis_tdata_o, 32'h0000_0022);
    tick(0, 3);
    check("full_pop_new_word", wfg_axis_tdata_o, 32'h0000_0044);
    wfg_axis_tready_i = 1'b0;

    // Disable with two words buffered
    pat_din_i = 8'h55;
    tick(1, 0); tick(0, 1); tick(0, 2);
    ctrl_en_q_i = 1'b0;
    tick(0, 3);
    pat_din_i = 8'h99;
    tick(1, 0); tick(0, 1); tick(0, 2); tick(0, 3);
    check("disabled_hold_tvalid", 32'(wfg_axis_tvalid_o), 32'd1);
    check("disabled_hold_tdata",  wfg_axis_tdata_o,       32'h0000_0044);
    wfg_axis_tready_i = 1'b1;
    tick(1, 0);
    check("drain_second", wfg_axis_tdata_o, 32'h0000_0055);
    tick(0, 1);
    check("drain_empty", 32'(wfg_axis_tvalid_o), 32'd0);
    tick(0, 2);
    check("disabled_no_sample", 32'(wfg_axis_tvalid_o), 32'd0);
    cfg_len_q_i = 8'd0; ctrl_en_q_i = 1'b1;
    tick(0, 3);
    pat_din_i = 8'h66;
    tick(1, 0); tick(0, 1); tick(0, 2);
    check("reenable_tdata", wfg_axis_tdata_o,      32'h0000_0066);
    check("reenable_cnt0",  32'(wfg_axis_tlast_o), 32'd1);
    tick(0, 3);

    // Reset mid-packet with words pending and overflow set
    cfg_len_q_i = 8'd3; wfg_axis_tready_i = 1'b0;
    pat_din_i = 8'h77;
    tick(1, 0); tick(0, 1); tick(0, 2); tick(0, 3);
    pat_din_i = 8'h78;
    tick(1, 0); tick(0, 1); tick(0, 2); tick(0, 3);
    pat_din_i = 8'h79;
    tick(1, 0); tick(0, 1); tick(0, 2);
    check("pre_rst_ovf",    32'(ovf_o),             32'd1);
    check("pre_rst_tvalid", 32'(wfg_axis_tvalid_o), 32'd1);
    tick(0, 3);
    tick(1, 0);
    rst = 1'b1;
    tick(0, 1);
    check("rst_tvalid", 32'(wfg_axis_tvalid_o), 32'd0);
    check("rst_ovf",    32'(ovf_o),             32'd0);
    check("rst_tlast",  32'(wfg_axis_tlast_o),  32'd0);
    check("rst_tdata",  wfg_axis_tdata_o,       32'd0);
    rst = 1'b0;
    tick(0, 2);
    check("rst_fsm_idle", 32'(wfg_axis_tvalid_o), 32'd0);
    tick(0, 3);
    cfg_len_q_i = 8'd0; wfg_axis_tready_i = 1'b1; pat_din_i = 8'h88;
    tick(1, 0); tick(0, 1); tick(0, 2);
    check("post_rst_tdata", wfg_axis_tdata_o,      32'h0000_0088);
    check("post_rst_cnt0",  32'(wfg_axis_tlast_o), 32'd1);
    tick(0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wfg_record_pat.md
WFG_RECORD_PAT -- requirements
Module: wfg_record_pat

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of sampled input pins (1..32).
REQ-002 SHALL have parameter AXIS_WIDTH, default 32, AXI-stream data width.
REQ-003 SHALL have port clk, input, 1, system clock; one clock domain only.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port pat_sync_i, input, 1, pattern-cycle start pulse (subcycle 0).
REQ-006 SHALL have port pat_subcycle_cnt_i, input, 8, current subcycle.
REQ-007 SHALL have port ctrl_en_q_i, input, 1, block enable.
REQ-008 SHALL have port cfg_sample_q_i, input, 8, subcycle at which the pins are sampled.
REQ-009 SHALL have port cfg_len_q_i, input, 8, words per packet minus 1.
REQ-010 SHALL have port pat_din_i, input, CHANNELS, input pins.
REQ-011 SHALL have port ovf_clr_i, input, 1, clears ovf_o.
REQ-012 SHALL have port wfg_axis_tvalid_o, output, 1, stream valid.
REQ-013 SHALL have port wfg_axis_tready_i, input, 1, stream ready.
REQ-014 SHALL have port wfg_axis_tlast_o, output, 1, last word of packet.
REQ-015 SHALL have port wfg_axis_tdata_o, output, AXIS_WIDTH, sampled word.
REQ-016 SHALL have port ovf_o, output, 1, sticky overflow flag.

Function
REQ-017 SHALL implement FSM with states IDLE, WAIT_SYNC and ARMED.
REQ-018 SHALL move IDLE->WAIT_SYNC when ctrl_en_q_i=1, and SHALL enter IDLE from any state in the cycle after ctrl_en_q_i=0.
REQ-019 In WAIT_SYNC with pat_sync_i=1, SHALL sample in that same cycle if pat_subcycle_cnt_i==cfg_sample_q_i and stay in WAIT_SYNC, else move to ARMED.
REQ-020 In ARMED, SHALL sample on the first cycle with pat_subcycle_cnt_i==cfg_sample_q_i and return to WAIT_SYNC.
REQ-021 In ARMED, pat_sync_i without a subcycle match SHALL keep the FSM in ARMED; at most one sample per pattern cycle.
REQ-022 A sample SHALL be pat_din_i zero-extended to AXIS_WIDTH, pushed with tlast = (word_cnt==cfg_len_q_i).
REQ-023 word_cnt (8 bit) SHALL increment per accepted sample and wrap to 0 after the tlast word; it SHALL clear in IDLE.
REQ-024 Samples SHALL be buffered in a 2-entry FIFO; a push SHALL be accepted if occupancy<2 or a pop occurs in the same cycle.
REQ-025 A rejected sample SHALL be dropped, leave word_cnt unchanged and set ovf_o the next cycle.
REQ-026 ovf_o SHALL clear on ovf_clr_i; a simultaneous set SHALL win.
REQ-027 wfg_axis_tvalid_o SHALL be 1 exactly when the FIFO is non-empty; tdata/tlast SHALL present the head entry.
REQ-028 A pop SHALL occur only on tvalid&tready; tvalid, tdata and tlast SHALL be held stable until then.
REQ-029 Latency: a sample taken in cycle N into an empty FIFO SHALL be visible with tvalid=1 in cycle N+1.
REQ-030 Disabling SHALL NOT flush the FIFO; buffered words drain normally.

Reset
REQ-031 rst=1 at a clock edge SHALL force FSM=IDLE, FIFO empty, word_cnt=0, ovf_o=0, tvalid=0, tlast=0, tdata=0, including mid-packet or with tvalid pending.
REQ-032 rst SHALL take priority over every other input.

Structure
REQ-033 Package wfg_record_pat_pkg SHALL hold the FSM state enum type and the FIFO depth constant (2).
REQ-034 The 2-entry FIFO SHALL be a sub-module wfg_record_pat_fifo storing {tlast, tdata}.

Verification
REQ-035 cfg_sample=3, cfg_len=1, tready=1, pins 0xA5 then 0x5A over two cycles -> words 0x000000A5 (tlast=0), 0x0000005A (tlast=1), each 1 cycle after subcycle 3.
REQ-036 cfg_sample=0, sync with subcycle 0 -> sample taken in the sync cycle, tvalid next cycle.
REQ-037 tready=0 for 3 pattern cycles -> first two words held stable, third dropped, ovf_o=1; ovf_clr_i then clears it.
REQ-038 Full FIFO, tready=1 in sample cycle -> sample accepted, no overflow.
REQ-039 ctrl_en_q_i dropped with 2 words buffered -> both drain, no new samples, word_cnt restarts at 0 on re-enable.
REQ-040 rst=1 with tvalid=1 mid-packet -> next cycle tvalid=0, ovf_o=0, FSM IDLE.
